// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU frame-buffer writer.
package ppu_pkg;

  typedef enum logic [1:0] {
    H_BLANK = 2'd0,
    V_BLANK = 2'd1,
    SCAN    = 2'd2,
    DRAW    = 2'd3
  } ppu_mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    VBL    = 2'd2
  } wr_state_t;

  localparam logic [7:0] LCD_W             = 8'd160;
  localparam logic [7:0] LCD_H             = 8'd144;
  localparam logic [5:0] FB_BYTES_PER_LINE = 6'd40;
  localparam int         FB_ADDR_W         = 14;
  localparam int         FB_OFS_W          = 13;

  // y*40 + x/4 built from shifts so no multiplier is inferred.
  function automatic logic [FB_OFS_W-1:0] fb_offset(input logic [7:0] y, input logic [7:0] x);
    logic [FB_OFS_W-1:0] yw;
    yw = {5'd0, y};
    return (yw << 5) + (yw << 3) + {7'd0, x[7:2]};
  endfunction

endpackage

// File: rtl/fb_pixel_packer.sv
// Packs 2-bit shades four to a byte, first pixel in [7:6]; flushes partial bytes at line end.
module fb_pixel_packer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       push,
  input  logic [1:0] px,
  input  logic       line_end,
  output logic       wr_req,
  output logic       wr,
  output logic [7:0] wdata
);

  logic [5:0] pack_reg;
  logic [5:0] pack_cur;
  logic [1:0] cnt_reg;
  logic [1:0] cnt_next;
  logic [2:0] fill;
  logic [7:0] byte_next;
  logic       wr_reg;
  logic [7:0] wdata_reg;

  always_comb begin
    pack_cur  = push ? {pack_reg[3:0], px} : pack_reg;
    fill      = {1'b0, cnt_reg} + {2'b00, push};
    byte_next = 8'h00;
    wr_req    = 1'b0;
    // A full group always wins; a coinciding line end then has nothing left to flush.
    case (fill)
      3'd4: begin
        byte_next = {pack_reg, px};
        wr_req    = 1'b1;
      end
      3'd3: begin
        byte_next = {pack_cur, 2'b00};
        wr_req    = line_end;
      end
      3'd2: begin
        byte_next = {pack_cur[3:0], 4'b0000};
        wr_req    = line_end;
      end
      3'd1: begin
        byte_next = {pack_cur[1:0], 6'b000000};
        wr_req    = line_end;
      end
      default: begin
        byte_next = 8'h00;
        wr_req    = 1'b0;
      end
    endcase
    if (clr) wr_req = 1'b0;
    cnt_next = (clr || line_end) ? 2'd0 : fill[1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pack_reg  <= 6'd0;
      cnt_reg   <= 2'd0;
      wr_reg    <= 1'b0;
      wdata_reg <= 8'h00;
    end else begin
      if (push) pack_reg <= pack_cur;
      cnt_reg <= cnt_next;
      wr_reg  <= wr_req;
      if (wr_req) wdata_reg <= byte_next;
    end
  end

  assign wr    = wr_reg;
  assign wdata = wdata_reg;

endmodule

// File: rtl/ppu_fb_writer.sv
// PPU pixel stream to double-buffered 2bpp frame buffer writer.
// FB_PALETTE_EN: when defined, shades go through BGP; otherwise raw indices are stored.
module ppu_fb_writer
  import ppu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           px_in,
  input  logic                 px_valid,
  input  logic [1:0]           ppu_mode,
  input  logic [7:0]           bgp,
  input  logic                 lcd_en,
  output logic                 fb_wr,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [7:0]           fb_wdata,
  output logic                 disp_buf,
  output logic                 frame_done,
  output logic                 overflow_err
);

  ppu_mode_t            mode;
  ppu_mode_t            prev_mode_reg;
  wr_state_t            state_reg;
  wr_state_t            state_next;
  logic [7:0]           x_reg, x_next;
  logic [7:0]           y_reg, y_next;
  logic                 wr_buf_reg;
  logic                 disp_buf_reg;
  logic                 frame_done_reg;
  logic                 overflow_reg;
  logic [FB_ADDR_W-1:0] fb_addr_reg;
  logic [1:0]           shade;
  logic                 accept;
  logic                 in_range;
  logic                 push;
  logic                 line_end;
  logic                 vbl_edge;
  logic                 frame_commit;
  logic                 wr_req;

  assign mode = ppu_mode_t'(ppu_mode);

`ifdef FB_PALETTE_EN
  assign shade = bgp[{px_in, 1'b0} +: 2];
`else
  logic unused_bgp;
  assign unused_bgp = ^bgp;
  assign shade      = px_in;
`endif

  assign accept   = px_valid && lcd_en;
  assign in_range = (x_reg < LCD_W) && (y_reg < LCD_H);
  assign push     = accept && in_range;
  assign line_end = lcd_en && (prev_mode_reg == DRAW) && (mode != DRAW);
  assign vbl_edge = (prev_mode_reg != V_BLANK) && (mode == V_BLANK);

  always_comb begin
    state_next   = state_reg;
    frame_commit = 1'b0;
    case (state_reg)
      IDLE: begin
        if (lcd_en) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (!lcd_en) begin
          state_next = IDLE;
        end else if (vbl_edge) begin
          state_next   = VBL;
          frame_commit = 1'b1;
        end
      end
      VBL: begin
        if (!lcd_en) state_next = IDLE;
        else if (mode != V_BLANK) state_next = ACTIVE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame end outranks line end for x/y; the flush address still uses this cycle's y.
  always_comb begin
    x_next = x_reg;
    y_next = y_reg;
    if (!lcd_en || frame_commit) begin
      x_next = 8'd0;
      y_next = 8'd0;
    end else if (line_end) begin
      x_next = 8'd0;
      if (y_reg < LCD_H) y_next = y_reg + 8'd1;
    end else if (push) begin
      x_next = x_reg + 8'd1;
    end
  end

  fb_pixel_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (!lcd_en),
    .push     (push),
    .px       (shade),
    .line_end (line_end),
    .wr_req   (wr_req),
    .wr       (fb_wr),
    .wdata    (fb_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_mode_reg  <= H_BLANK;
      state_reg      <= IDLE;
      x_reg          <= 8'd0;
      y_reg          <= 8'd0;
      wr_buf_reg     <= 1'b0;
      disp_buf_reg   <= 1'b1;
      frame_done_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      fb_addr_reg    <= '0;
    end else begin
      prev_mode_reg  <= mode;
      state_reg      <= state_next;
      x_reg          <= x_next;
      y_reg          <= y_next;
      frame_done_reg <= frame_commit;
      if (frame_commit) begin
        disp_buf_reg <= wr_buf_reg;
        wr_buf_reg   <= ~wr_buf_reg;
      end
      if (accept && !in_range) overflow_reg <= 1'b1;
      if (wr_req) fb_addr_reg <= {wr_buf_reg, fb_offset(y_reg, x_reg)};
    end
  end

  assign fb_addr      = fb_addr_reg;
  assign disp_buf     = disp_buf_reg;
  assign frame_done   = frame_done_reg;
  assign overflow_err = overflow_reg;

endmodule
